// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-port shift-add multiplier arbiter.
package mult_arbiter_pkg;

    localparam int unsigned MULT_MAX_LAT = 18;
    localparam int unsigned MULT_PORTS   = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mult_state_e;

    // Partial product for one radix-4 step: two multiplier bits against the multiplicand.
    function automatic logic [31:0] mult_partial(input logic [1:0] bits,
                                                 input logic [31:0] mcand);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = bits[0] ? mcand : 32'd0;
        hi = bits[1] ? {mcand[30:0], 1'b0} : 32'd0;
        return lo + hi;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Multiplier datapath: scans the multiplier two bits per step into a running accumulator.
module mult_core
    import mult_arbiter_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] bits_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] acc_i,
    output logic        zero_o,
    output logic [31:0] acc_o
);

    logic [31:0] bits_q, bits_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] acc_q, acc_d;

    // Next-state: load fresh operands, or consume two multiplier bits per step.
    always_comb begin
        bits_d  = bits_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        if (load_i) begin
            bits_d  = bits_i;
            mcand_d = mcand_i;
            acc_d   = acc_i;
        end else if (step_i) begin
            acc_d   = acc_q + mult_partial(bits_q[1:0], mcand_q);
            bits_d  = {2'b00, bits_q[31:2]};
            mcand_d = {mcand_q[29:0], 2'b00};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            bits_q  <= bits_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    assign zero_o = (bits_q == 32'd0);
    assign acc_o  = acc_q;

endmodule

// File: rtl/mult_arbiter.sv
// Two-port round-robin arbiter in front of a shared multiply-accumulate core.
module mult_arbiter
    import mult_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MULT_PORTS-1:0] req,
    input  logic [MULT_PORTS-1:0] flush,
    input  logic [31:0]           acc0_0,
    input  logic [31:0]           acc0_1,
    input  logic [31:0]           in0_0,
    input  logic [31:0]           in0_1,
    input  logic [31:0]           in1_0,
    input  logic [31:0]           in1_1,
    output logic [MULT_PORTS-1:0] gnt,
    output logic [MULT_PORTS-1:0] ack,
    output logic [31:0]           result,
    output logic                  result_n,
    output logic                  result_z,
    output logic                  busy,
    output logic                  owner
);

    mult_state_e state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;     // port granted most recently
    logic [31:0] result_q, result_d;

    logic [MULT_PORTS-1:0] elig;
    logic [MULT_PORTS-1:0] gnt_c;
    logic [MULT_PORTS-1:0] ack_c;
    logic                  sel;
    logic                  load;
    logic                  step;
    logic                  core_zero;
    logic [31:0]           core_acc;

    assign elig = req & ~flush;
    // With both eligible, the port not granted last wins.
    assign sel  = (elig == 2'b11) ? ~last_q : elig[1];

    mult_core u_core (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load),
        .step_i  (step),
        .bits_i  (sel ? in0_1 : in0_0),
        .mcand_i (sel ? in1_1 : in1_0),
        .acc_i   (sel ? acc0_1 : acc0_0),
        .zero_o  (core_zero),
        .acc_o   (core_acc)
    );

    // FSM next-state, grant/ack decode and datapath controls.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_c   = '0;
        ack_c   = '0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|elig) begin
                    gnt_c[sel] = 1'b1;
                    load       = 1'b1;
                    owner_d    = sel;
                    last_d     = sel;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (flush[owner_q]) begin
                    state_d = StIdle;
                end else if (core_zero) begin
                    state_d = StDone;
                end else begin
                    step = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flush[owner_q]) begin
                    ack_c[owner_q] = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result register only changes on a delivered ack, so a flushed DONE leaves it intact.
    always_comb begin
        result_d = result_q;
        if (|ack_c) begin
            result_d = core_acc;
        end
    end

    // State, ownership, round-robin pointer and held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
        end
    end

    // Grant is combinational from req; mask it so reset forces it low immediately.
    assign gnt      = rst ? '0 : gnt_c;
    assign ack      = rst ? '0 : ack_c;
    assign result   = (|ack) ? core_acc : result_q;
    assign result_n = result[31];
    assign result_z = (result == 32'd0);
    assign busy     = (state_q != StIdle);
    assign owner    = owner_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, flush;
    logic [31:0] acc0_0, acc0_1, in0_0, in0_1, in1_0, in1_1;
    logic [1:0]  gnt, ack;
    logic [31:0] result;
    logic        result_n, result_z, busy, owner;

    mult_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .flush    (flush),
        .acc0_0   (acc0_0),
        .acc0_1   (acc0_1),
        .in0_0    (in0_0),
        .in0_1    (in0_1),
        .in1_0    (in1_0),
        .in1_1    (in1_1),
        .gnt      (gnt),
        .ack      (ack),
        .result   (result),
        .result_n (result_n),
        .result_z (result_z),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester stimulus state.
    logic        p_pend [2];
    logic [31:0] p_in0  [2];
    logic [31:0] p_in1  [2];
    logic [31:0] p_acc  [2];
    logic [1:0]  fl_v;

    // Reference model state.
    logic        m_busy;
    int          m_owner, m_last, m_ack_at;
    logic [31:0] m_exp, m_res;

    // Observations for directed scenarios.
    int          gnt_cyc [2];
    int          ack_cyc [2];
    logic [31:0] ack_res [2];
    logic        ack_n   [2];
    logic        ack_z   [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int kbits(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return i + 1;
        end
        return 0;
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            gnt_cyc[i] = -1;
            ack_cyc[i] = -1;
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 0;
        m_last   = 1;
        m_ack_at = 0;
        m_exp    = '0;
        m_res    = '0;
    endtask

    // Predict this cycle's outputs from the request/flush rules and compare.
    task automatic model_check();
        logic [1:0] el, eg, ea;
        logic       exp_busy;
        int         p;
        eg = '0;
        ea = '0;
        exp_busy = m_busy;
        el = req & ~flush;
        if (!m_busy) begin
            if (el != 2'b00) begin
                p = (el == 2'b11) ? 1 - m_last : (el[1] ? 1 : 0);
                eg[p]    = 1'b1;
                m_last   = p;
                m_owner  = p;
                m_busy   = 1'b1;
                m_exp    = p_in0[p] * p_in1[p] + p_acc[p];
                m_ack_at = cyc + 2 + (kbits(p_in0[p]) + 1) / 2;
            end
        end else if (flush[m_owner]) begin
            m_busy = 1'b0;
        end else if (cyc == m_ack_at) begin
            ea[m_owner]     = 1'b1;
            m_res           = m_exp;
            m_busy          = 1'b0;
            p_pend[m_owner] = 1'b0;
        end
        check_val("gnt", 32'(gnt), 32'(eg));
        check_val("ack", 32'(ack), 32'(ea));
        check_val("busy", 32'(busy), 32'(exp_busy));
        if (exp_busy) check_val("owner", 32'(owner), 32'(m_owner));
        check_val("result", result, m_res);
        check_val("result_n", 32'(result_n), 32'(m_res[31]));
        check_val("result_z", 32'(result_z), 32'(m_res == 32'd0));
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) gnt_cyc[i] = cyc;
            if (ack[i]) begin
                ack_cyc[i] = cyc;
                ack_res[i] = result;
                ack_n[i]   = result_n;
                ack_z[i]   = result_z;
            end
            if (flush[i]) p_pend[i] = 1'b0;
        end
    endtask

    // One clock: drive inputs, check at the falling edge, return just after the next rise.
    task automatic tick();
        req    = {p_pend[1], p_pend[0]};
        flush  = fl_v;
        in0_0  = p_in0[0];
        in0_1  = p_in0[1];
        in1_0  = p_in1[0];
        in1_1  = p_in1[1];
        acc0_0 = p_acc[0];
        acc0_1 = p_acc[1];
        @(negedge clk);
        model_check();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        p_pend[p] = 1'b1;
        p_in0[p]  = a;
        p_in1[p]  = b;
        p_acc[p]  = c;
    endtask

    task automatic run_until_ack(input int p, input int limit);
        for (int i = 0; i < limit && ack_cyc[p] < 0; i++) tick();
        check_val("ack_timeout", 32'(ack_cyc[p] >= 0), 32'd1);
    endtask

    // Assert reset (asynchronously, mid-cycle), check forced outputs, release after two edges.
    task automatic do_reset();
        rst       = 1'b1;
        req       = 2'b11;
        flush     = 2'b00;
        p_pend[0] = 1'b0;
        p_pend[1] = 1'b0;
        fl_v      = 2'b00;
        #1;
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_owner", 32'(owner), 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_n", 32'(result_n), 32'd0);
        check_val("rst_z", 32'(result_z), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_obs();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_pend[i] = 1'b0;
            p_in0[i]  = '0;
            p_in1[i]  = '0;
            p_acc[i]  = '0;
        end
        fl_v = 2'b00;
        model_reset();
        clear_obs();
        do_reset();

        // Small multiply-accumulate on port 0.
        set_req(0, 32'h3, 32'h7, 32'hA);
        run_until_ack(0, 30);
        check_val("d23_lat", 32'(ack_cyc[0] - gnt_cyc[0]), 32'd3);
        check_val("d23_res", ack_res[0], 32'h1F);
        check_val("d23_n", 32'(ack_n[0]), 32'd0);
        check_val("d23_z", 32'(ack_z[0]), 32'd0);

        // Longest operation on port 1.
        clear_obs();
        set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        run_until_ack(1, 30);
        check_val("d24_lat", 32'(ack_cyc[1] - gnt_cyc[1]), 32'd18);
        check_val("d24_res", ack_res[1], 32'h1);

        // Both ports from reset: port 0 first, then alternate.
        do_reset();
        set_req(0, 32'h1, 32'h2, 32'h0);
        set_req(1, 32'h1, 32'h2, 32'h0);
        run_until_ack(1, 40);
        check_val("d25_lat0", 32'(ack_cyc[0] - gnt_cyc[0]), 32'd3);
        check_val("d25_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd4);
        check_val("d25_res", ack_res[0], 32'h2);
        clear_obs();
        set_req(0, 32'h1, 32'h2, 32'h0);
        set_req(1, 32'h1, 32'h2, 32'h0);
        run_until_ack(1, 40);
        check_val("d25_rr", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd4);

        // Owner flush mid-run hands the engine to the waiting port.
        do_reset();
        set_req(0, 32'hFFFF_0000, 32'h1234, 32'h0);
        tick();
        set_req(1, 32'h5, 32'h3, 32'h1);
        repeat (4) tick();
        fl_v = 2'b01;
        tick();
        fl_v = 2'b00;
        tick();
        check_val("d26_gnt1", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd6);
        run_until_ack(1, 30);
        check_val("d26_noack0", 32'(ack_cyc[0]), 32'hFFFF_FFFF);

        // Zero multiplier with zero addend.
        clear_obs();
        set_req(0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        run_until_ack(0, 30);
        check_val("d27_lat", 32'(ack_cyc[0] - gnt_cyc[0]), 32'd2);
        check_val("d27_res", ack_res[0], 32'h0);
        check_val("d27_z", 32'(ack_z[0]), 32'd1);

        // Reset in the middle of a long operation.
        clear_obs();
        set_req(1, 32'hFFFF_FFFF, 32'h3, 32'h0);
        repeat (4) tick();
        do_reset();
        set_req(0, 32'h2, 32'h9, 32'h0);
        tick();
        check_val("d28_gnt", 32'(gnt_cyc[0]), 32'(cyc - 1));
        run_until_ack(0, 30);
        check_val("d28_noack1", 32'(ack_cyc[1]), 32'hFFFF_FFFF);
        check_val("d28_res", ack_res[0], 32'h12);

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_pend[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, $urandom >> $urandom_range(0, 32), $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
                end
                fl_v[i] = ($urandom_range(0, 19) == 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
